hazard_flush_ctrl: RTL

Pipeline hazard and flush controller that drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers (`IF_ID_Write`, `IF_ID_Flush`, `ID_EX_Flush`) and the PC write enable. It sits beside the ID stage and watches ID-stage operand usage and EX-stage load and branch status. It detects load-use hazards, squashes wrong-path instructions on jumps and taken branches, and sequences a pipeline drain and halt when a `halt` instruction reaches ID.

---
 rtl/hazard_pkg.sv | 74 +++++++
 rtl/load_use_detect.sv | 23 ++
 rtl/hazard_flush_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/flush controller: FSM states, register-zero
// constant and the control-output bundle with its fixed per-case patterns.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pcWre;
      logic ifIdWrite;
      logic ifIdFlush;
      logic idExFlush;
      logic halted;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{
      pcWre: 1'b0, ifIdWrite: 1'b0,
      ifIdFlush: 1'b1, idExFlush: 1'b1,
      halted: 1'b0
   };

   localparam ctrl_t CTRL_BRANCH = '{
      pcWre: 1'b1, ifIdWrite: 1'b1,
      ifIdFlush: 1'b1, idExFlush: 1'b1,
      halted: 1'b0
   };

   localparam ctrl_t CTRL_STALL = '{
      pcWre: 1'b0, ifIdWrite: 1'b0,
      ifIdFlush: 1'b0, idExFlush: 1'b1,
      halted: 1'b0
   };

   localparam ctrl_t CTRL_JUMP = '{
      pcWre: 1'b1, ifIdWrite: 1'b1,
      ifIdFlush: 1'b1, idExFlush: 1'b0,
      halted: 1'b0
   };

   // Halt moves on into EX; fetch stops and the slot behind it is bubbled.
   localparam ctrl_t CTRL_HALT_IN = '{
      pcWre: 1'b0, ifIdWrite: 1'b0,
      ifIdFlush: 1'b1, idExFlush: 1'b0,
      halted: 1'b0
   };

   localparam ctrl_t CTRL_IDLE = '{
      pcWre: 1'b1, ifIdWrite: 1'b1,
      ifIdFlush: 1'b0, idExFlush: 1'b0,
      halted: 1'b0
   };

   localparam ctrl_t CTRL_DRAIN = '{
      pcWre: 1'b0, ifIdWrite: 1'b0,
      ifIdFlush: 1'b1, idExFlush: 1'b1,
      halted: 1'b0
   };

   localparam ctrl_t CTRL_HALT = '{
      pcWre: 1'b0, ifIdWrite: 1'b0,
      ifIdFlush: 1'b1, idExFlush: 1'b1,
      halted: 1'b1
   };

   function automatic logic [1:0] drainLoad(input int cycles);
      return 2'(cycles - 1);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the load in EX writes a register
// that the instruction in ID actually reads.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_UseRs,
   input  logic       ID_UseRt,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rt,
   output logic       lu
);

   logic rsHit;
   logic rtHit;

   assign rsHit = ID_UseRs && (ID_rs == EX_rt);
   assign rtHit = ID_UseRt && (ID_rt == EX_rt);

   assign lu = EX_MemRead && (EX_rt != REG_ZERO) && (rsHit || rtHit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Hazard, flush and halt-drain controller beside the ID stage.
// Optional perf counters: define HAZARD_STATS_EN.
module hazard_flush_ctrl
   import hazard_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_UseRs,
   input  logic       ID_UseRt,
   input  logic       ID_Jump,
   input  logic       ID_Halt,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rt,
   input  logic       EX_BranchTaken,
   output logic       PCWre,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Flush,
   output logic       Halted
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
`endif
);

   state_t     state;
   state_t     nextState;
   logic [1:0] cnt;
   logic [1:0] nextCnt;
   ctrl_t      ctrl;
   logic       lu;

   logic runBranch;
   logic runStall;
   logic runJump;
   logic runHalt;
   logic runIdle;

   load_use_detect uLud (
      .ID_rs      (ID_rs),
      .ID_rt      (ID_rt),
      .ID_UseRs   (ID_UseRs),
      .ID_UseRt   (ID_UseRt),
      .EX_MemRead (EX_MemRead),
      .EX_rt      (EX_rt),
      .lu         (lu)
   );

   // One-hot RUN decision, priority resolved up front.
   assign runBranch = EX_BranchTaken;
   assign runStall  = !EX_BranchTaken && lu;
   assign runJump   = !EX_BranchTaken && !lu && ID_Jump;
   assign runHalt   = !EX_BranchTaken && !lu && !ID_Jump && ID_Halt;
   assign runIdle   = !EX_BranchTaken && !lu && !ID_Jump && !ID_Halt;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= ST_RUN;
         cnt   <= 2'd0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      unique case (state)
         ST_RUN: begin
            if (runHalt) begin
               nextState = ST_DRAIN;
               nextCnt   = drainLoad(DRAIN_CYCLES);
            end
         end
         ST_DRAIN: begin
            if (cnt == 2'd0) begin
               nextState = ST_HALT;
            end else begin
               nextCnt = cnt - 2'd1;
            end
         end
         ST_HALT: begin
            nextState = ST_HALT;
         end
         default: begin
            nextState = ST_RUN;
            nextCnt   = 2'd0;
         end
      endcase
   end

   always_comb begin
      ctrl = CTRL_RESET;
      if (Reset) begin
         unique case (state)
            ST_RUN: begin
               unique case (1'b1)
                  runBranch: ctrl = CTRL_BRANCH;
                  runStall:  ctrl = CTRL_STALL;
                  runJump:   ctrl = CTRL_JUMP;
                  runHalt:   ctrl = CTRL_HALT_IN;
                  runIdle:   ctrl = CTRL_IDLE;
                  default:   ctrl = CTRL_IDLE;
               endcase
            end
            ST_DRAIN: ctrl = CTRL_DRAIN;
            ST_HALT:  ctrl = CTRL_HALT;
            default:  ctrl = CTRL_RESET;
         endcase
      end
   end

   assign PCWre       = ctrl.pcWre;
   assign IF_ID_Write = ctrl.ifIdWrite;
   assign IF_ID_Flush = ctrl.ifIdFlush;
   assign ID_EX_Flush = ctrl.idExFlush;
   assign Halted      = ctrl.halted;

`ifdef HAZARD_STATS_EN
   // Counters only move in RUN, so they freeze through DRAIN and HALT.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         StallCount <= 32'd0;
         FlushCount <= 32'd0;
      end else if (state == ST_RUN) begin
         if (runStall) begin
            StallCount <= StallCount + 32'd1;
         end
         if (EX_BranchTaken || ID_Jump) begin
            FlushCount <= FlushCount + 32'd1;
         end
      end
   end
`endif

endmodule
